// File: rtl/spart_rx_fifo.sv
// SPART receive path: oversampled serial frame recovery with majority voting,
// parity/framing checks and a small receive FIFO drained by the bus side.
module spart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rxEnable,
    input  logic                          RxD,
    input  logic                          rd,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          RDA,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] T_LO   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] T_MID  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] T_VOTE = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] T_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   FULL   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t                 state, state_nx;
    logic                   sync1, rxs;
    logic [CW-1:0]          cnt, cnt_nx;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   s_lo, s_mid, vote, at_vote, perr;
    logic                   push_req, set_perr, set_ferr, set_ovr;
    logic                   do_push, do_pop, full;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= RxD;
            rxs   <= sync1;
        end
    end

    // The counter is cleared on the tick that first sees the start edge, so
    // cnt_nx is the index of the current tick within the bit.
    assign cnt_nx  = (cnt == T_LAST) ? '0 : cnt + CW'(1);
    assign at_vote = rxEnable && (cnt_nx == T_VOTE);
    assign vote    = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);
    assign full    = (count == FULL);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        push_req = 1'b0;
        set_perr = 1'b0;
        set_ferr = 1'b0;
        set_ovr  = 1'b0;
        if (rxEnable) begin
            case (state)
                IDLE:   if (!rxs) state_nx = START;
                START:  if (at_vote) state_nx = vote ? IDLE : DATA;
                DATA:   if (at_vote && bit_cnt == B_LAST)
                            state_nx = (PARITY_EN != 0) ? PARITY : STOP;
                PARITY: if (at_vote) state_nx = STOP;
                STOP: begin
                    if (at_vote) begin
                        if (!vote) begin
                            set_ferr = 1'b1;
                            state_nx = BREAK;
                        end else begin
                            state_nx = IDLE;
                            if (perr)             set_perr = 1'b1;
                            else if (full && !rd) set_ovr  = 1'b1;
                            else                  push_req = 1'b1;
                        end
                    end
                end
                BREAK:  if (rxs) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            s_lo    <= 1'b1;
            s_mid   <= 1'b1;
            perr    <= 1'b0;
        end else if (rxEnable) begin
            if (state == IDLE) begin
                cnt     <= '0;
                bit_cnt <= '0;
                perr    <= 1'b0;
            end else begin
                cnt <= cnt_nx;
                if (cnt_nx == T_LO)  s_lo  <= rxs;
                if (cnt_nx == T_MID) s_mid <= rxs;
                if (state == DATA && cnt_nx == T_VOTE) begin
                    shreg   <= {vote, shreg[DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + BW'(1);
                end
                if (state == PARITY && cnt_nx == T_VOTE)
                    perr <= ((^shreg) ^ vote) != (PARITY_ODD != 0);
            end
        end
    end

    // A pop on a full FIFO frees the slot, so push_req already excludes
    // only the full-without-pop case.
    assign do_push = push_req;
    assign do_pop  = rd && (count != '0);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= set_perr | (parity_err & ~clr_err);
            frame_err  <= set_ferr | (frame_err  & ~clr_err);
            overrun    <= set_ovr  | (overrun    & ~clr_err);
        end
    end

    assign RDA        = (count != '0);
    assign fifo_count = count;
    assign rx_data    = RDA ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Directed bench for spart_rx_fifo: three parameterisations share one clock and
// baud tick; good frames are pushed to per-instance scoreboards and popped on read.
module tb_spart_rx_fifo;

    logic clk;
    logic [1:0] div = '0;
    logic rx_en;
    logic rxd  [3];
    logic rd   [3];
    logic clr  [3];
    logic rstn [3];

    logic [7:0] rx_a, rx_p;
    logic [8:0] rx_n;
    logic rda_a, rda_p, rda_n;
    logic [2:0] cnt_a, cnt_p, cnt_n;
    logic pe_a, fe_a, ov_a, pe_p, fe_p, ov_p, pe_n, fe_n, ov_n;

    logic [8:0] sb_a[$], sb_p[$], sb_n[$];
    int tests = 0;
    int fails = 0;

    // 8N1, OVERSAMPLE 16, depth 4
    spart_rx_fifo u_a (
        .clk(clk), .rst_n(rstn[0]), .rxEnable(rx_en), .RxD(rxd[0]), .rd(rd[0]),
        .clr_err(clr[0]), .rx_data(rx_a), .RDA(rda_a), .fifo_count(cnt_a),
        .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a));

    // 8E1
    spart_rx_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) u_p (
        .clk(clk), .rst_n(rstn[1]), .rxEnable(rx_en), .RxD(rxd[1]), .rd(rd[1]),
        .clr_err(clr[1]), .rx_data(rx_p), .RDA(rda_p), .fifo_count(cnt_p),
        .parity_err(pe_p), .frame_err(fe_p), .overrun(ov_p));

    // 9N1, OVERSAMPLE 8
    spart_rx_fifo #(.DATA_BITS(9), .OVERSAMPLE(8)) u_n (
        .clk(clk), .rst_n(rstn[2]), .rxEnable(rx_en), .RxD(rxd[2]), .rd(rd[2]),
        .clr_err(clr[2]), .rx_data(rx_n), .RDA(rda_n), .fifo_count(cnt_n),
        .parity_err(pe_n), .frame_err(fe_n), .overrun(ov_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) div <= div + 2'd1;
    assign rx_en = (div == 2'd3);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stop at a negedge whose following posedge carries a baud tick.
    task automatic align();
        do @(negedge clk); while (rx_en !== 1'b1);
    endtask

    task automatic drive(input int d, input logic v, input int os);
        rxd[d] = v;
        repeat (os * 4) @(negedge clk);
    endtask

    task automatic frame(input int d, input logic [8:0] data, input int nb, input int os,
                         input bit pe, input bit pb, input bit stop, input bit good);
        align();
        if (good) begin
            case (d)
                0: sb_a.push_back(data);
                1: sb_p.push_back(data);
                default: sb_n.push_back(data);
            endcase
        end
        drive(d, 1'b0, os);
        for (int i = 0; i < nb; i++) drive(d, data[i], os);
        if (pe) drive(d, pb, os);
        drive(d, stop, os);
    endtask

    task automatic pop_check(input int d);
        logic [8:0] exp, got;
        logic rdv;
        exp = '0;
        case (d)
            0: begin got = {1'b0, rx_a}; rdv = rda_a; if (sb_a.size() > 0) exp = sb_a.pop_front(); end
            1: begin got = {1'b0, rx_p}; rdv = rda_p; if (sb_p.size() > 0) exp = sb_p.pop_front(); end
            default: begin got = rx_n; rdv = rda_n; if (sb_n.size() > 0) exp = sb_n.pop_front(); end
        endcase
        chk($sformatf("rda_before_pop%0d", d), rdv, 1);
        chk($sformatf("rx_data%0d", d), got, exp);
        rd[d] = 1'b1;
        @(negedge clk);
        rd[d] = 1'b0;
    endtask

    task automatic pulse_clr(input int d);
        clr[d] = 1'b1;
        @(negedge clk);
        clr[d] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rxd[i] = 1'b1; rd[i] = 1'b0; clr[i] = 1'b0; rstn[i] = 1'b0;
        end
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) rstn[i] = 1'b1;

        // reset state
        chk("rst_rda", rda_a, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_rx_data", rx_a, 0);
        chk("rst_flags", {pe_a, fe_a, ov_a}, 0);
        chk("rst_rx_data_n", rx_n, 0);

        // back-to-back 8N1
        frame(0, 9'h0A5, 8, 16, 0, 0, 1, 1);
        frame(0, 9'h03C, 8, 16, 0, 0, 1, 1);
        @(negedge clk);
        chk("b2b_count", cnt_a, 2);
        pop_check(0);
        pop_check(0);
        chk("b2b_empty_rda", rda_a, 0);
        chk("b2b_empty_count", cnt_a, 0);

        // 3-tick glitch is a false start
        align();
        rxd[0] = 1'b0;
        repeat (12) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (64) @(negedge clk);
        chk("glitch_count", cnt_a, 0);
        chk("glitch_flags", {pe_a, fe_a, ov_a}, 0);
        frame(0, 9'h055, 8, 16, 0, 0, 1, 1);
        @(negedge clk);
        pop_check(0);

        // even parity
        frame(1, 9'h007, 8, 16, 1, 0, 1, 0);
        @(negedge clk);
        chk("par_err_set", pe_p, 1);
        chk("par_count", cnt_p, 0);
        pulse_clr(1);
        chk("par_err_clr", pe_p, 0);
        frame(1, 9'h007, 8, 16, 1, 1, 1, 1);
        @(negedge clk);
        chk("par_good_flag", pe_p, 0);
        chk("par_good_count", cnt_p, 1);
        pop_check(1);

        // stop bit low for two bit periods
        frame(0, 9'h000, 8, 16, 0, 0, 0, 0);
        repeat (64) @(negedge clk);
        chk("ferr_set", fe_a, 1);
        chk("ferr_count", cnt_a, 0);
        rxd[0] = 1'b1;
        repeat (64) @(negedge clk);
        chk("ferr_no_frame", cnt_a, 0);
        frame(0, 9'h081, 8, 16, 0, 0, 1, 1);
        @(negedge clk);
        chk("ferr_sticky", fe_a, 1);
        pop_check(0);
        pulse_clr(0);
        chk("ferr_clr", fe_a, 0);

        // overrun
        for (int i = 1; i <= 5; i++) frame(0, 9'(i), 8, 16, 0, 0, 1, i <= 4);
        @(negedge clk);
        chk("ovr_count", cnt_a, 4);
        chk("ovr_flag", ov_a, 1);
        for (int i = 0; i < 4; i++) pop_check(0);
        chk("ovr_drained", rda_a, 0);
        pulse_clr(0);
        chk("ovr_clr", ov_a, 0);

        // pop on the same edge as the 5th push: slot freed, no overrun
        for (int i = 1; i <= 4; i++) frame(0, 9'(i), 8, 16, 0, 0, 1, 1);
        fork
            frame(0, 9'h005, 8, 16, 0, 0, 1, 1);
            begin
                align();
                repeat (4 * ((1 + 8) * 16 + 16 / 2 + 2)) @(negedge clk);
                pop_check(0);
            end
        join
        @(negedge clk);
        chk("rdpush_ovr", ov_a, 0);
        chk("rdpush_count", cnt_a, 4);
        for (int i = 0; i < 4; i++) pop_check(0);

        // 9-bit, oversample 8, reset mid-frame
        frame(2, 9'h1FF, 9, 8, 0, 0, 1, 1);
        @(negedge clk);
        chk("n9_count", cnt_n, 1);
        chk("n9_data", rx_n, 9'h1FF);
        frame(2, 9'h000, 9, 8, 0, 0, 0, 0);
        rxd[2] = 1'b1;
        repeat (32) @(negedge clk);
        chk("n9_ferr", fe_n, 1);
        align();
        drive(2, 1'b0, 8);
        for (int i = 0; i < 4; i++) drive(2, i[0], 8);
        rxd[2] = 1'b1;
        rstn[2] = 1'b0;
        repeat (3) @(negedge clk);
        rstn[2] = 1'b1;
        sb_n.delete();
        chk("n9_rst_count", cnt_n, 0);
        chk("n9_rst_rda", rda_n, 0);
        chk("n9_rst_ferr", fe_n, 0);
        chk("n9_rst_data", rx_n, 0);
        repeat (64) @(negedge clk);
        frame(2, 9'h123, 9, 8, 0, 0, 1, 1);
        @(negedge clk);
        chk("n9_after_count", cnt_n, 1);
        chk("n9_after_flags", {pe_n, fe_n, ov_n}, 0);
        pop_check(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
